// File: rtl/pop_pointers.sv
// rtl/pop_pointers.sv - read-side pointer, occupancy and flag controller for the RAM FIFO
module pop_pointers #(
   parameter int ADDR_W = 4,
   parameter int AF_LVL = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pop,
   input  logic              clear,
   input  logic              w_en,
   input  logic [ADDR_W-1:0] w_add,
   output logic [ADDR_W-1:0] r_add,
   output logic              r_en,
   output logic              rd_valid,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int             DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] AF_CNT    = AF_LVL[ADDR_W:0];

   typedef enum logic [1:0] {
      S_EMPTY  = 2'd0,
      S_NORMAL = 2'd1,
      S_FULL   = 2'd2,
      S_ERR    = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W:0]   count_nxt;
   logic              ovf_set;
   logic              unf_set;

   // Flags come from the registered count only, so pop/w_en never reach them combinationally.
   assign empty       = (count == '0);
   assign full        = (count == DEPTH_CNT);
   assign almost_full = (count >= AF_CNT);

   // A read is launched only when data exists; the error state freezes the read side.
   assign r_en = pop & ~empty & (state != S_ERR);

   // Next occupancy and state: state follows the next count unless an overflow latches S_ERR.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      ovf_set   = 1'b0;
      unf_set   = pop & empty;
      if (state != S_ERR) begin
         if (w_en && !r_en) begin
            if (count == DEPTH_CNT) begin
               ovf_set = 1'b1;
            end else begin
               count_nxt = count + 1'b1;
            end
         end else if (!w_en && r_en) begin
            count_nxt = count - 1'b1;
         end
         if (ovf_set) begin
            state_nxt = S_ERR;
         end else if (count_nxt == '0) begin
            state_nxt = S_EMPTY;
         end else if (count_nxt == DEPTH_CNT) begin
            state_nxt = S_FULL;
         end else begin
            state_nxt = S_NORMAL;
         end
      end
   end

   // State, pointer, occupancy and sticky status registers; clear realigns to the push pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_EMPTY;
         r_add     <= '0;
         count     <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         state     <= S_EMPTY;
         r_add     <= w_add;
         count     <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         rd_valid  <= r_en;
         overflow  <= overflow | ovf_set;
         underflow <= underflow | unf_set;
         if (r_en) begin
            r_add <= r_add + 1'b1;
         end
      end
   end

   // Outside the error state the read pointer plus occupancy must land on the push pointer.
   property p_ptr_align;
      @(posedge clk) disable iff (reset)
         (state != S_ERR) |-> ((r_add + count[ADDR_W-1:0]) == w_add);
   endproperty
   a_ptr_align: assert property (p_ptr_align);

endmodule
